video_pll_lock_sequencer: RTL and testbench

Reset/lock controller for the VGA subsystem video PLL (50 MHz refclk in; 25/25/33 MHz outputs).
- Drives the PLL reset and qualifies its asynchronous `locked` output.
- Holds downstream video-domain logic in reset until lock has been stable for a programmable time.
- Re-sequences the PLL on loss of lock or on software request, with bounded retries and a sticky fault.
- Runs entirely in the refclk domain.

---
 rtl/video_pll_lock_sequencer_if.sv | 25 ++
 rtl/video_pll_lock_sequencer.sv | 134 +++++++++++++
 tb/tb_video_pll_lock_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/video_pll_lock_sequencer_if.sv
// Video PLL lock sequencer signal bundle.
// master: the side that drives lock/relock (PLL wrapper or bench).
// slave:  the sequencer itself.
`timescale 1ns/1ps

interface video_pll_lock_sequencer_if;
    logic       pll_locked;   // raw PLL locked, asynchronous to refclk
    logic       relock_req;   // single-cycle restart request
    logic       pll_rst;      // reset to the PLL
    logic       video_rst;    // reset for video-domain logic
    logic       ready;        // PLL locked and qualified
    logic       fault;        // sticky: retries exhausted
    logic [1:0] retry_count;  // retries consumed in this sequence
    logic [2:0] state;        // FSM state, for debug

    modport master (
        output pll_locked, relock_req,
        input  pll_rst, video_rst, ready, fault, retry_count, state
    );

    modport slave (
        input  pll_locked, relock_req,
        output pll_rst, video_rst, ready, fault, retry_count, state
    );
endinterface

// File: rtl/video_pll_lock_sequencer.sv
// Reset/lock controller for the VGA video PLL, running in the refclk domain.
// Holds the PLL in reset, waits for a synchronized lock, requires the lock to
// stay up for LOCK_STABLE_CYCLES before releasing video reset, and retries a
// bounded number of times before parking in a sticky FAULT state.
`timescale 1ns/1ps

module video_pll_lock_sequencer #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                        refclk,
    input  logic                        rst,
    video_pll_lock_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // One counter is shared by all timed states, so it is sized for the
    // largest of the three durations.
    localparam int MAX_AB = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    logic [1:0]       sync_q;
    logic             lock_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;

    // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], bus.pll_locked};
    end

    assign lock_s = sync_q[1];

    // State, shared counter and retry count registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Next-state, retry and counter logic; relock_req overrides every event.
    // NOTE: all outputs of this block get a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + 2'd1;
                    end
                end
            end
            STABLE: begin
                // A dropout sends us back to WAIT_LOCK with a fresh timeout;
                // retries are not charged for it.
                if (!lock_s)                   state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            FAULT: begin
                // Terminal until relock_req or rst.
            end
            default: begin
                state_d = PLL_RST;
                retry_d = '0;
            end
        endcase

        // Software restart; ignored while the PLL is already being reset so
        // a stuck request cannot stretch the reset pulse.
        if (bus.relock_req && (state_q != PLL_RST)) begin
            state_d = PLL_RST;
            retry_d = '0;
        end

        // Counter restarts on every transition and only runs in timed states.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == PLL_RST) || (state_q == WAIT_LOCK) || (state_q == STABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are a pure decode of the state register.
    assign bus.pll_rst     = (state_q == PLL_RST) || (state_q == FAULT);
    assign bus.video_rst   = (state_q != RUN);
    assign bus.ready       = (state_q == RUN);
    assign bus.fault       = (state_q == FAULT);
    assign bus.retry_count = retry_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_video_pll_lock_sequencer.sv
// Directed bench for video_pll_lock_sequencer with RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
// Each step queues the output snapshots it expects cycle by cycle; the
// queue is drained at falling edges against the DUT outputs.
`timescale 1ns/1ps

module tb_video_pll_lock_sequencer;

    localparam logic [2:0] S_PLL_RST = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_STABLE  = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    logic refclk = 1'b0;
    logic rst;

    video_pll_lock_sequencer_if bus();

    video_pll_lock_sequencer #(
        .RST_CYCLES          (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    // Scoreboard: parallel queues of tags and expected output vectors.
    string      tag_q[$];
    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [8:0] obs;
    assign obs = {bus.state, bus.retry_count, bus.pll_rst, bus.video_rst, bus.ready, bus.fault};

    // Expected outputs for a given state and retry count, from the output decode rules.
    function automatic logic [8:0] expect_vec(input logic [2:0] st, input logic [1:0] rc);
        logic p, v, r, f;
        p = (st == S_PLL_RST) || (st == S_FAULT);
        v = (st != S_RUN);
        r = (st == S_RUN);
        f = (st == S_FAULT);
        return {st, rc, p, v, r, f};
    endfunction

    task automatic push(input string tag, input logic [2:0] st, input logic [1:0] rc, input int n);
        for (int i = 0; i < n; i++) begin
            tag_q.push_back(tag);
            exp_q.push_back(expect_vec(st, rc));
        end
    endtask

    task automatic check_now();
        string      tag;
        logic [8:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed=%h required=<entry>", obs);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed state=%0d retry=%0d rst/vrst/rdy/flt=%b required state=%0d retry=%0d rst/vrst/rdy/flt=%b",
                       tag, obs[8:6], obs[5:4], obs[3:0], e[8:6], e[5:4], e[3:0]);
            end
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            @(negedge refclk);
            check_now();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        repeat (2) @(negedge refclk);

        // Scenario 1: reset state, 4-cycle PLL reset, lock qualification.
        push("reset_state", S_PLL_RST, 2'd0, 1);
        drain();
        rst = 1'b0;
        push("s1_pll_rst", S_PLL_RST, 2'd0, 3);
        push("s1_wait",    S_WAIT,    2'd0, 7);
        drain();
        bus.pll_locked = 1'b1;
        push("s1_sync",    S_WAIT,    2'd0, 2);
        push("s1_stable",  S_STABLE,  2'd0, 8);
        push("s1_run",     S_RUN,     2'd0, 3);
        drain();

        // Scenario 4: lock loss in RUN, then one timeout retry.
        bus.pll_locked = 1'b0;
        push("s4_run_hold",  S_RUN,     2'd0, 2);
        push("s4_pll_rst",   S_PLL_RST, 2'd0, 4);
        push("s4_timeout",   S_WAIT,    2'd0, 32);
        push("s4_retry_rst", S_PLL_RST, 2'd1, 4);
        push("s4_wait",      S_WAIT,    2'd1, 3);
        drain();

        // Scenario 3: 3-cycle dropout at STABLE count 5.
        bus.pll_locked = 1'b1;
        push("s3_sync",        S_WAIT,   2'd1, 2);
        push("s3_stable_pre",  S_STABLE, 2'd1, 6);
        drain();
        bus.pll_locked = 1'b0;
        push("s3_stable_tail", S_STABLE, 2'd1, 2);
        push("s3_wait",        S_WAIT,   2'd1, 1);
        drain();
        bus.pll_locked = 1'b1;
        push("s3_resync",      S_WAIT,   2'd1, 2);
        push("s3_stable",      S_STABLE, 2'd1, 8);
        push("s3_run",         S_RUN,    2'd1, 2);
        drain();

        // Scenario 5: relock from RUN, held relock ignored in PLL_RST,
        // then relock colliding with STABLE->RUN.
        bus.relock_req = 1'b1;
        push("s5_run_relock", S_PLL_RST, 2'd0, 1);
        drain();
        push("s5_ignored",    S_PLL_RST, 2'd0, 2);
        drain();
        bus.relock_req = 1'b0;
        push("s5_pll_rst",    S_PLL_RST, 2'd0, 1);
        push("s5_wait",       S_WAIT,    2'd0, 1);
        push("s5_stable",     S_STABLE,  2'd0, 8);
        drain();
        bus.relock_req = 1'b1;
        push("s5_stable_relock", S_PLL_RST, 2'd0, 1);
        drain();
        bus.relock_req = 1'b0;
        push("s5_pll_rst2",   S_PLL_RST, 2'd0, 3);
        push("s5_wait2",      S_WAIT,    2'd0, 1);
        push("s5_stable2",    S_STABLE,  2'd0, 8);
        push("s5_run",        S_RUN,     2'd0, 2);
        drain();

        // Scenario 2: no lock at all, retries exhausted, sticky fault, relock.
        bus.pll_locked = 1'b0;
        push("s2_run_hold", S_RUN,     2'd0, 2);
        push("s2_rst0",     S_PLL_RST, 2'd0, 4);
        push("s2_wait0",    S_WAIT,    2'd0, 32);
        push("s2_rst1",     S_PLL_RST, 2'd1, 4);
        push("s2_wait1",    S_WAIT,    2'd1, 32);
        push("s2_rst2",     S_PLL_RST, 2'd2, 4);
        push("s2_wait2",    S_WAIT,    2'd2, 32);
        push("s2_fault",    S_FAULT,   2'd2, 5);
        drain();
        bus.relock_req = 1'b1;
        push("s2_relock",   S_PLL_RST, 2'd0, 1);
        drain();
        bus.relock_req = 1'b0;
        push("s2_new_rst",  S_PLL_RST, 2'd0, 3);
        push("s2_new_wait", S_WAIT,    2'd0, 2);
        drain();

        // Scenario 6a: asynchronous reset in WAIT_LOCK.
        push("s6_async_wait", S_PLL_RST, 2'd0, 1);
        #2 rst = 1'b1;
        #1 check_now();
        @(negedge refclk);
        push("s6_held", S_PLL_RST, 2'd0, 1);
        check_now();
        rst = 1'b0;
        push("s6a_pll_rst", S_PLL_RST, 2'd0, 3);
        push("s6a_wait",    S_WAIT,    2'd0, 3);
        drain();
        bus.pll_locked = 1'b1;
        push("s6a_sync",    S_WAIT,    2'd0, 2);
        push("s6a_stable",  S_STABLE,  2'd0, 8);
        push("s6a_run",     S_RUN,     2'd0, 2);
        drain();

        // Scenario 6b: asynchronous reset in RUN; lock is still present.
        push("s6_async_run", S_PLL_RST, 2'd0, 1);
        #2 rst = 1'b1;
        #1 check_now();
        @(negedge refclk);
        rst = 1'b0;
        push("s6b_pll_rst", S_PLL_RST, 2'd0, 3);
        push("s6b_wait",    S_WAIT,    2'd0, 1);
        push("s6b_stable",  S_STABLE,  2'd0, 8);
        push("s6b_run",     S_RUN,     2'd0, 2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
